// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg: FSM state encoding, fixed AXI4 single-beat attributes and default AXI IDs shared by the bridge
package sram_axi_bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RELEASE} state_t;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] DEF_INST_ID = 4'd0;
  localparam logic [3:0] DEF_DATA_ID = 4'd1;
endpackage

// File: rtl/sram_axi_bridge_if.sv
// sram_axi_bridge_if: AXI4 bundle (ar, r, aw, w, b channels) with master (bridge) and slave (memory) modports
interface sram_axi_bridge_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic rvalid;
  logic rready;
  logic [3:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic bvalid;
  logic bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wvalid, bready,
    input arready, rid, rdata, rvalid, awready, wready, bvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge_inst_fetch_buf.sv
// inst_fetch_buf: one-entry fetch buffer (ports: clk, resetn, lookup_addr -> hit/data, fill_* write, inval clears valid)
module inst_fetch_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] lookup_addr,
  input  logic        fill,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic        inval,
  output logic        hit,
  output logic [31:0] data
);
  logic valid;
  logic [31:0] tag;
  assign hit = valid && tag == lookup_addr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid <= 1'b0;
      tag <= '0;
      data <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag <= fill_addr;
      data <= fill_data;
    end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: CPU inst/data SRAM ports to single-outstanding AXI4 master (ports: clk, resetn, inst_sram_*, data_sram_*, bus_stall, axi master modport); BRIDGE_INST_BUF_EN adds a one-entry fetch buffer
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = DEF_INST_ID,
  parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        bus_stall,
  sram_axi_bridge_if.master axi
);
  state_t state;
  logic inst_served;
  logic data_served;
  logic inst_pend;
  logic data_pend;
  logic is_store;
  logic r_inst;
  logic buf_hit;
  logic [31:0] buf_data;
  assign inst_pend = inst_sram_en && !inst_served;
  assign data_pend = data_sram_en && !data_served;
  assign is_store = |data_sram_wen;
  assign r_inst = axi.rid == INST_ID;
  assign bus_stall = resetn && (inst_pend || data_pend || (state != IDLE && state != RELEASE));
  assign axi.arlen = AXI_LEN_SINGLE;
  assign axi.arsize = AXI_SIZE_WORD;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.awid = DATA_ID;
  assign axi.awlen = AXI_LEN_SINGLE;
  assign axi.awsize = AXI_SIZE_WORD;
  assign axi.awburst = AXI_BURST_INCR;
`ifdef BRIDGE_INST_BUF_EN
  inst_fetch_buf u_fetch_buf (
    .clk(clk),
    .resetn(resetn),
    .lookup_addr(inst_sram_addr),
    .fill(state == RD_DATA && axi.rvalid && r_inst),
    .fill_addr(axi.araddr),
    .fill_data(axi.rdata),
    .inval(state == IDLE && data_pend && is_store),
    .hit(buf_hit),
    .data(buf_data)
  );
`else
  assign buf_hit = 1'b0;
  assign buf_data = '0;
`endif
  // completion goes straight to RELEASE when nothing else is pending, giving the N+3 read turnaround
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      inst_served <= 1'b0;
      data_served <= 1'b0;
      axi.arid <= '0;
      axi.araddr <= '0;
      axi.arvalid <= 1'b0;
      axi.rready <= 1'b0;
      axi.awaddr <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata <= '0;
      axi.wstrb <= '0;
      axi.wvalid <= 1'b0;
      axi.bready <= 1'b0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (data_pend && is_store) begin
            axi.awaddr <= data_sram_addr;
            axi.wdata <= data_sram_wdata;
            axi.wstrb <= data_sram_wen;
            axi.awvalid <= 1'b1;
            axi.wvalid <= 1'b1;
            state <= WR_ADDR;
          end else if (data_pend || (inst_pend && !buf_hit)) begin
            axi.araddr <= data_pend ? data_sram_addr : inst_sram_addr;
            axi.arid <= data_pend ? DATA_ID : INST_ID;
            axi.arvalid <= 1'b1;
            state <= RD_ADDR;
          end else if (inst_pend) begin
            inst_sram_rdata <= buf_data;
            inst_served <= 1'b1;
            state <= RELEASE;
          end else if (inst_served || data_served) begin
            state <= RELEASE;
          end
        RD_ADDR:
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready <= 1'b1;
            state <= RD_DATA;
          end
        RD_DATA:
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            if (r_inst) begin
              inst_sram_rdata <= axi.rdata;
              inst_served <= 1'b1;
              state <= data_pend ? IDLE : RELEASE;
            end else begin
              data_sram_rdata <= axi.rdata;
              data_served <= 1'b1;
              state <= inst_pend ? IDLE : RELEASE;
            end
          end
        WR_ADDR: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready) axi.wvalid <= 1'b0;
          if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
            axi.bready <= 1'b1;
            state <= WR_RESP;
          end
        end
        WR_RESP:
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            data_served <= 1'b1;
            state <= inst_pend ? IDLE : RELEASE;
          end
        RELEASE: begin
          inst_served <= 1'b0;
          data_served <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: table-driven bench with AXI slave model and AR/AW expectation queues for sram_axi_bridge
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;
  localparam logic [3:0] IID = 4'd3;
  localparam logic [3:0] DID = 4'd6;
  typedef struct {
    logic ie;
    logic [31:0] ia;
    logic de;
    logic [3:0] wen;
    logic [31:0] da;
    logic [31:0] wd;
    int hold;
    logic hit;
    int lat;
  } vec_t;
  typedef struct {
    logic [3:0] id;
    logic [31:0] addr;
  } ar_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
  } aw_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = '0;
  logic [31:0] inst_sram_rdata;
  logic data_sram_en = 1'b0;
  logic [3:0] data_sram_wen = '0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic bus_stall;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_start = 0;
  int hold_len = 0;
  int b_cnt = 0;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_data = '0;
  ar_t ar_q[$];
  aw_t aw_q[$];
  vec_t vecs[9];
  always #5 clk = ~clk;
  sram_axi_bridge_if axi();
  sram_axi_bridge #(.INST_ID(IID), .DATA_ID(DID)) dut (
    .clk(clk),
    .resetn(resetn),
    .inst_sram_en(inst_sram_en),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .bus_stall(bus_stall),
    .axi(axi)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'hBFC00000 ? 32'h3C080001 : {a[15:0], ~a[15:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // AXI slave: handshakes are observed at negedge and their effects applied just after the next posedge
  initial begin
    logic arf, rf, awf, wf, bf, aw_got, w_got, prev_arv, prev_arf;
    logic [31:0] prev_ara, lat_addr;
    logic [3:0] lat_id;
    ar_t e;
    aw_got = 0; w_got = 0; prev_arv = 0; prev_arf = 0; prev_ara = '0; lat_addr = '0; lat_id = '0;
    axi.arready = 1; axi.rvalid = 0; axi.rid = '0; axi.rdata = '0;
    axi.awready = 1; axi.wready = 1; axi.bvalid = 0;
    forever begin
      @(negedge clk);
      arf = resetn && axi.arvalid && axi.arready;
      rf = resetn && axi.rvalid && axi.rready;
      awf = resetn && axi.awvalid && axi.awready;
      wf = resetn && axi.wvalid && axi.wready;
      bf = resetn && axi.bvalid && axi.bready;
      if (resetn && prev_arv && !prev_arf) begin
        chk("arvalid_hold", {31'd0, axi.arvalid}, 32'd1);
        chk("araddr_hold", axi.araddr, prev_ara);
      end
      prev_arv = resetn && axi.arvalid;
      prev_arf = arf;
      prev_ara = axi.araddr;
      if (arf) begin
        if (ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got id %h addr %h expected no read", axi.arid, axi.araddr);
        end else begin
          e = ar_q.pop_front();
          chk("arid", {28'd0, axi.arid}, {28'd0, e.id});
          chk("araddr", axi.araddr, e.addr);
        end
        lat_id = axi.arid;
        lat_addr = axi.araddr;
      end
      if ((awf || wf) && aw_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL aw_unexpected: got addr %h expected no write", axi.awaddr);
      end else begin
        if (awf) chk("awaddr", axi.awaddr, aw_q[0].addr);
        if (wf) begin
          chk("wdata", axi.wdata, aw_q[0].data);
          chk("wstrb", {28'd0, axi.wstrb}, {28'd0, aw_q[0].strb});
        end
      end
      if (bf) b_cnt++;
      @(posedge clk); #1;
      cyc++;
      if (!resetn) begin
        axi.rvalid = 0; axi.bvalid = 0; aw_got = 0; w_got = 0; prev_arv = 0;
      end else begin
        if (rf) axi.rvalid = 0;
        if (bf) axi.bvalid = 0;
        if (arf) begin
          axi.rvalid = 1; axi.rid = lat_id; axi.rdata = mem(lat_addr);
        end
        aw_got = aw_got || awf;
        w_got = w_got || wf;
        if (aw_got && w_got) begin
          axi.bvalid = 1; aw_got = 0; w_got = 0;
          if (aw_q.size() > 0) void'(aw_q.pop_front());
        end
      end
      axi.arready = !(hold_len > 0 && cyc >= hold_start && cyc < hold_start + hold_len);
    end
  end
  task automatic run_req(input vec_t v);
    int n, b0;
    @(negedge clk);
    hold_len = v.hold;
    hold_start = cyc + 1;
    b0 = b_cnt;
    if (v.de && v.wen != 0) aw_q.push_back(aw_t'{v.da, v.wd, v.wen});
    else if (v.de) ar_q.push_back(ar_t'{DID, v.da});
    if (v.ie && !v.hit) ar_q.push_back(ar_t'{IID, v.ia});
    if (v.ie) exp_inst = mem(v.ia);
    if (v.de && v.wen == 0) exp_data = mem(v.da);
    @(posedge clk); #1;
    inst_sram_en = v.ie; inst_sram_addr = v.ia;
    data_sram_en = v.de; data_sram_wen = v.wen; data_sram_addr = v.da; data_sram_wdata = v.wd;
    n = 0;
    @(negedge clk);
    while (bus_stall && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("latency", n, v.lat);
    chk("inst_rdata", inst_sram_rdata, exp_inst);
    chk("data_rdata", data_sram_rdata, exp_data);
    chk("ar_left", ar_q.size(), 0);
    chk("aw_left", aw_q.size(), 0);
    chk("b_count", b_cnt - b0, (v.de && v.wen != 0) ? 1 : 0);
    ar_q.delete();
    aw_q.delete();
    @(posedge clk); #1;
    inst_sram_en = 0; data_sram_en = 0; data_sram_wen = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end
  initial begin
    vec_t v;
    int hit_lat;
    logic hit_exp;
    vecs[0] = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h00002000, 32'h0, 0, 1'b0, 3};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h00001000, 32'hDEADBEEF, 0, 1'b0, 3};
    vecs[3] = '{1'b1, 32'hBFC00004, 1'b1, 4'h0, 32'h00002004, 32'h0, 0, 1'b0, 6};
    vecs[4] = '{1'b1, 32'hBFC00008, 1'b1, 4'hF, 32'h00001004, 32'h12345678, 0, 1'b0, 6};
    vecs[5] = '{1'b1, 32'hBFC0000C, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, 3};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 4'b1000, 32'h00000010, 32'hA5000000, 0, 1'b0, 3};
    vecs[7] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h00003000, 32'h0, 0, 1'b0, 3};
    vecs[8] = '{1'b1, 32'h00000400, 1'b0, 4'h0, 32'h0, 32'h0, 5, 1'b0, 7};
    inst_sram_en = 1; inst_sram_addr = 32'hBFC00000; data_sram_en = 1; data_sram_addr = 32'h2000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, bus_stall}, 0);
    chk("rst_valids", {27'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    chk("rst_data_rdata", data_sram_rdata, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", {28'd0, axi.wstrb}, 0);
    chk("ar_attr", {19'd0, axi.arlen, axi.arsize, axi.arburst}, {19'd0, 8'd0, 3'd2, 2'b01});
    chk("aw_attr", {15'd0, axi.awid, axi.awlen, axi.awsize, axi.awburst}, {15'd0, DID, 8'd0, 3'd2, 2'b01});
    inst_sram_en = 0; data_sram_en = 0;
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 9; i++) run_req(vecs[i]);
    @(negedge clk);
    hold_len = 0;
    ar_q.push_back(ar_t'{IID, 32'h00000500});
    @(posedge clk); #1;
    inst_sram_en = 1; inst_sram_addr = 32'h00000500;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2;
    chk("rd_data_rready", {31'd0, axi.rready}, 1);
    resetn = 0;
    inst_sram_en = 0;
    #1;
    chk("mid_rst_stall", {31'd0, bus_stall}, 0);
    chk("mid_rst_valids", {27'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    chk("mid_rst_inst_rdata", inst_sram_rdata, 0);
    chk("mid_rst_data_rdata", data_sram_rdata, 0);
    chk("mid_rst_araddr", axi.araddr, 0);
    exp_inst = '0;
    exp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    run_req('{1'b1, 32'hBFC00010, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, 3});
`ifdef BRIDGE_INST_BUF_EN
    hit_exp = 1'b1;
    hit_lat = 1;
`else
    hit_exp = 1'b0;
    hit_lat = 3;
`endif
    v = '{1'b1, 32'h00000100, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, 3};
    run_req(v);
    v.hit = hit_exp;
    v.lat = hit_lat;
    run_req(v);
    run_req('{1'b0, 32'h0, 1'b1, 4'hF, 32'h00002000, 32'h0BADF00D, 0, 1'b0, 3});
    run_req('{1'b1, 32'h00000100, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, 3});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter INST_ID, default 4'd0: AXI ID driven on instruction reads.
REQ-002 Parameter DATA_ID, default 4'd1: AXI ID driven on data reads and writes.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 inst_sram_en, inst_sram_addr  in  1/32  CPU fetch request and word address.
REQ-006 inst_sram_rdata  out  32  fetched instruction.
REQ-007 data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata  in  1/4/32/32  CPU load/store request; wen!=0 means store.
REQ-008 data_sram_rdata  out  32  load result.
REQ-009 bus_stall  out  1  freezes the CPU pipeline while a request is being serviced.
REQ-010 arid/araddr/arvalid out 4/32/1; arready in 1: AXI read-address channel.
REQ-011 rid/rdata/rvalid in 4/32/1; rready out 1: AXI read-data channel.
REQ-012 awaddr/awvalid out 32/1; awready in 1; wdata/wstrb/wvalid out 32/4/1; wready in 1; bvalid in 1; bready out 1: AXI write channels.
REQ-013 arlen/awlen out 8 = 0; arsize/awsize out 3 = 3'd2; arburst/awburst out 2 = 2'b01; awid out 4 = DATA_ID.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP and RELEASE.
REQ-015 IDLE: a pending data request SHALL win over a pending fetch; the bridge goes to RD_ADDR for a load or fetch and to WR_ADDR for a store.
REQ-016 A request is pending when its en=1 and its served flag is 0; bus_stall SHALL be 1 combinationally whenever any request is pending or the FSM is not in IDLE/RELEASE.
REQ-017 RD_ADDR: arvalid=1 with araddr and arid latched at entry; on arvalid&arready the FSM goes to RD_DATA.
REQ-018 RD_DATA: rready=1; on rvalid it captures rdata into the owning port's rdata register (selected by rid), sets that port's served flag, and returns to IDLE.
REQ-019 WR_ADDR: awvalid and wvalid SHALL assert together, each dropping independently on its own handshake; when both have completed the FSM goes to WR_RESP.
REQ-020 WR_RESP: bready=1; on bvalid the data served flag is set and the FSM returns to IDLE.
REQ-021 When every asserted en has its served flag set, the FSM SHALL enter RELEASE for exactly one cycle with bus_stall=0; both served flags clear at the end of RELEASE.
REQ-022 inst_sram_rdata and data_sram_rdata SHALL hold their value from capture until the next capture for the same port.
REQ-023 At most one AXI transaction SHALL be outstanding; valid signals SHALL NOT drop before their handshake.
REQ-024 Latency for an uncontended read with ready/valid tied high: request seen in cycle N, AR handshake in N+1, R in N+2, RELEASE in N+3.
REQ-025 Both ports active in the same cycle: data completes, then fetch, then a single RELEASE.

Reset
REQ-026 resetn low SHALL force: FSM=IDLE, served flags=0, all AXI valid/ready outputs=0, rdata outputs=0, and araddr/awaddr/wdata/wstrb=0.
REQ-027 bus_stall SHALL be 0 while resetn is low.
REQ-028 Reset mid-transaction SHALL abandon the transaction, with no partial rdata update.

Configuration
REQ-029 With BRIDGE_INST_BUF_EN defined, a one-entry fetch buffer (tag, valid) SHALL satisfy a fetch whose address equals the tag in IDLE with no AXI traffic; any store clears the buffer valid bit.
REQ-030 Without BRIDGE_INST_BUF_EN, every fetch SHALL issue an AXI read; the buffer logic is absent.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the AXI size/burst constants and the default IDs.
REQ-032 The optional fetch buffer SHALL be a sub-module, inst_fetch_buf.

Verification
REQ-033 Fetch 0xBFC00000 with ready tied 1 and rdata=0x3C080001 -> inst_sram_rdata=0x3C080001 and bus_stall low exactly in cycle N+3.
REQ-034 Store wen=4'b0011 to 0x00001000 -> AW and W carry addr 0x00001000 and wstrb 4'b0011; bus_stall released only after bvalid.
REQ-035 Fetch and load in the same cycle -> the first AR carries arid=DATA_ID and the second arid=INST_ID; a single RELEASE cycle.
REQ-036 Hold arready=0 for 5 cycles -> arvalid and araddr stay stable; bus_stall stays 1 throughout.
REQ-037 resetn pulsed low during RD_DATA -> all outputs return to their reset values and the next fetch completes normally.
REQ-038 BRIDGE_INST_BUF_EN defined, two fetches of 0x100 -> only one arvalid handshake; then a store followed by a fetch of 0x100 -> a new AR is issued.
